// File: rtl/fft_symbol_sched.sv
// Symbol-level sequencer for the PUSCH FFT datapath: admits N samples per symbol,
// waits for the reorder stage to emit N samples, and tracks symbols per slot.
module fft_symbol_sched #(
  parameter int N       = 256,
  parameter int LOG2N   = 8,
  parameter int SYMS    = 14,
  parameter int TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             fft_en,
  output logic             fft_rst,
  input  logic             rd_en,
  output logic [3:0]       sym_idx,
  output logic [LOG2N-1:0] out_cnt,
  output logic             busy,
  output logic             slot_done,
  output logic             err,
  output logic [1:0]       dbg_state_o
);

  // Handshake: a sample transfers in every cycle where s_valid && s_ready;
  // s_ready depends only on registered state, never on s_valid.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [LOG2N-1:0] CNT_MAX  = LOG2N'(N - 1);
  localparam logic [3:0]       SYM_MAX  = 4'(SYMS - 1);
  localparam logic [9:0]       WAIT_MAX = 10'(TIMEOUT);

  state_t           state_q, state_d;
  logic [LOG2N-1:0] in_cnt_q, in_cnt_d;
  logic [LOG2N-1:0] out_cnt_q, out_cnt_d;
  logic [3:0]       sym_q, sym_d;
  logic [9:0]       wait_q, wait_d;
  logic             fft_rst_q, fft_rst_d;
  logic             slot_done_q, slot_done_d;
  logic             err_q, err_d;

  assign s_ready     = (state_q == LOAD);
  assign fft_en      = s_valid & s_ready;
  assign busy        = (state_q != IDLE);
  assign fft_rst     = fft_rst_q;
  assign slot_done   = slot_done_q;
  assign err         = err_q;
  assign sym_idx     = sym_q;
  assign out_cnt     = out_cnt_q;
  assign dbg_state_o = state_q;

  always_comb begin
    state_d     = state_q;
    in_cnt_d    = in_cnt_q;
    out_cnt_d   = out_cnt_q;
    sym_d       = sym_q;
    wait_d      = wait_q;
    err_d       = err_q;
    fft_rst_d   = 1'b0;
    slot_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = LOAD;
          err_d     = 1'b0;
          fft_rst_d = 1'b1;
          in_cnt_d  = '0;
          out_cnt_d = '0;
          sym_d     = '0;
          wait_d    = '0;
        end
      end
      LOAD: begin
        if (fft_en) begin
          if (in_cnt_q == CNT_MAX) begin
            in_cnt_d = '0;
            wait_d   = '0;
            state_d  = WAIT;
          end else begin
            in_cnt_d = in_cnt_q + 1'b1;
          end
        end
      end
      WAIT: begin
        if (rd_en) begin
          // This first reordered sample is index 0; the next expected index is 1.
          out_cnt_d = 1;
          wait_d    = '0;
          state_d   = DRAIN;
        end else if (wait_q == WAIT_MAX) begin
          err_d     = 1'b1;
          fft_rst_d = 1'b1;
          state_d   = IDLE;
          out_cnt_d = '0;
          sym_d     = '0;
          wait_d    = '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      DRAIN: begin
        if (rd_en) begin
          wait_d = '0;
          if (out_cnt_q == CNT_MAX) begin
            out_cnt_d = '0;
            if (sym_q == SYM_MAX) begin
              sym_d       = '0;
              slot_done_d = 1'b1;
              state_d     = IDLE;
            end else begin
              sym_d   = sym_q + 1'b1;
              state_d = LOAD;
            end
          end else begin
            out_cnt_d = out_cnt_q + 1'b1;
          end
        end else if (wait_q == WAIT_MAX) begin
          err_d     = 1'b1;
          fft_rst_d = 1'b1;
          state_d   = IDLE;
          out_cnt_d = '0;
          sym_d     = '0;
          wait_d    = '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort overrides everything above once a slot is running; err is left as-is.
    if (abort && (state_q != IDLE)) begin
      state_d     = IDLE;
      in_cnt_d    = '0;
      out_cnt_d   = '0;
      sym_d       = '0;
      wait_d      = '0;
      err_d       = err_q;
      fft_rst_d   = 1'b1;
      slot_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      sym_q       <= '0;
      wait_q      <= '0;
      fft_rst_q   <= 1'b0;
      slot_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      sym_q       <= sym_d;
      wait_q      <= wait_d;
      fft_rst_q   <= fft_rst_d;
      slot_done_q <= slot_done_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_fft_symbol_sched.sv
// Randomized bench for fft_symbol_sched: drives symbols/slots and checks against a
// transaction-level model of symbol counting, slot completion, timeout and abort.
module tb_fft_symbol_sched;

  localparam int N       = 256;
  localparam int LOG2N   = 8;
  localparam int SYMS    = 14;
  localparam int TIMEOUT = 1023;

  logic             clk, rst, start, abort, s_valid, rd_en;
  logic             s_ready, fft_en, fft_rst, busy, slot_done, err;
  logic [3:0]       sym_idx;
  logic [LOG2N-1:0] out_cnt;
  logic [1:0]       dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];
  int exp_sym   = 0;
  int exp_sdone = 0;
  int sdone_cnt = 0;

  logic             o_ready, o_en, o_frst, o_sdone, o_busy, o_err;
  logic [3:0]       o_sym;
  logic [LOG2N-1:0] o_out;

  fft_symbol_sched #(.N(N), .LOG2N(LOG2N), .SYMS(SYMS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .s_valid(s_valid), .s_ready(s_ready), .fft_en(fft_en), .fft_rst(fft_rst),
    .rd_en(rd_en), .sym_idx(sym_idx), .out_cnt(out_cnt), .busy(busy),
    .slot_done(slot_done), .err(err), .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // One clock cycle: apply inputs, snapshot outputs mid-cycle, advance past the edge.
  task automatic cyc(input logic sv, input logic rd, input logic st, input logic ab);
    s_valid = sv; rd_en = rd; start = st; abort = ab;
    #1;
    o_ready = s_ready; o_en = fft_en; o_frst = fft_rst; o_sdone = slot_done;
    o_busy = busy; o_err = err; o_sym = sym_idx; o_out = out_cnt;
    if (slot_done) sdone_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic do_start();
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    exp_sym = 0;
    check("start_busy", o_busy, 1);
    check("start_fft_rst", o_frst, 1);
    check("start_err_clr", o_err, 0);
    check("start_ready", o_ready, 1);
    check("start_sym", o_sym, 0);
  endtask

  task automatic load_sym(input int target, input bit hold);
    int cnt = 0;
    int budget = 0;
    int frst = 0;
    int bad_en = 0;
    logic sv;
    while (cnt < target && budget < 8 * N) begin
      sv = hold ? 1'b1 : ($urandom_range(0, 3) != 0);
      cyc(sv, $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0, 1'b0);
      if (o_en) cnt++;
      if (o_en !== (sv & o_ready)) bad_en++;
      frst += o_frst;
      budget++;
    end
    check("load_accepts", cnt, target);
    check("load_fft_en_comb", bad_en, 0);
    check("load_sym_idx", o_sym, exp_sym);
    if (target == N) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      check("ready_drop", o_ready, 0);
      check("no_extra_accept", o_en, 0);
      check("wait_busy", o_busy, 1);
      frst += o_frst;
    end
    check("load_no_fft_rst", frst, 0);
  endtask

  task automatic drain_sym(input int gap);
    int bad = 0;
    int leak = 0;
    int frst = 0;
    bit last;
    repeat (gap) begin
      cyc(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
      leak += o_en + o_ready; frst += o_frst;
    end
    for (int k = 0; k < N; k++) begin
      if ($urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 3)) begin
          cyc(1'b1, 1'b0, 1'b0, 1'b0);
          leak += o_en + o_ready; frst += o_frst;
        end
      cyc(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
      if (o_out !== k[LOG2N-1:0]) bad++;
      leak += o_en + o_ready; frst += o_frst;
    end
    check("drain_out_cnt_seq", bad, 0);
    check("drain_no_accept", leak, 0);
    check("drain_no_fft_rst", frst, 0);
    last = (exp_sym == SYMS - 1);
    exp_sym = (exp_sym + 1) % SYMS;
    exp_q.push_back(exp_sym);
    if (last) exp_sdone++;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("sym_idx_after", o_sym, exp_q.pop_front());
    check("slot_done_pulse", o_sdone, last);
    check("busy_after", o_busy, !last);
    check("ready_after", o_ready, !last);
  endtask

  initial begin
    int wc;
    rst = 1'b1; start = 1'b0; abort = 1'b0; s_valid = 1'b0; rd_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_ready", s_ready, 0);
    check("rst_fft_en", fft_en, 0);
    check("rst_fft_rst", fft_rst, 0);
    check("rst_busy", busy, 0);
    check("rst_slot_done", slot_done, 0);
    check("rst_err", err, 0);
    check("rst_sym_idx", sym_idx, 0);
    check("rst_out_cnt", out_cnt, 0);
    rst = 1'b0;

    // rd_en and abort in IDLE are ignored
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check("idle_busy", o_busy, 0);
    check("idle_out_cnt", o_out, 0);
    check("idle_no_accept", o_en, 0);
    check("idle_abort_no_rst", o_frst, 0);

    // full slot, first symbol with a 10-cycle gap before the reorder output
    do_start();
    for (int s = 0; s < SYMS; s++) begin
      load_sym(N, (s % 2) == 0);
      drain_sym((s == 0) ? 10 : $urandom_range(0, 40));
    end
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check("slot_idle_busy", o_busy, 0);
    check("slot_idle_sym", o_sym, 0);

    // reorder output never arrives
    do_start();
    load_sym(N, 1'b1);
    wc = 1;
    do begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      if (!o_err) wc++;
    end while (!o_err && wc < 2000);
    check("timeout_wait_cycles", wc, TIMEOUT + 1);
    check("timeout_err", o_err, 1);
    check("timeout_fft_rst", o_frst, 1);
    check("timeout_idle", o_busy, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("err_sticky", o_err, 1);
    do_start();

    // abort at in_cnt=100 of symbol 3
    for (int s = 0; s < 3; s++) begin
      load_sym(N, 1'b0);
      drain_sym($urandom_range(0, 20));
    end
    load_sym(100, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    exp_sym = 0;
    check("abort_idle", o_busy, 0);
    check("abort_sym", o_sym, 0);
    check("abort_fft_rst", o_frst, 1);
    check("abort_no_slot_done", o_sdone, 0);
    check("abort_err_kept", o_err, 0);
    do_start();
    for (int s = 0; s < SYMS; s++) begin
      load_sym(N, 1'b0);
      drain_sym($urandom_range(0, 30));
    end

    // asynchronous reset in the middle of DRAIN
    do_start();
    load_sym(N, 1'b0);
    repeat (50) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    s_valid = 1'b1;
    #3 rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_s_ready", s_ready, 0);
    check("arst_fft_en", fft_en, 0);
    check("arst_out_cnt", out_cnt, 0);
    check("arst_sym_idx", sym_idx, 0);
    check("arst_slot_done", slot_done, 0);
    check("arst_fft_rst", fft_rst, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_sym = 0;
    exp_q.delete();
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("arst_release_idle", o_busy, 0);
    do_start();
    load_sym(N, 1'b1);
    drain_sym(5);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("final_abort_idle", o_busy, 0);

    check("slot_done_total", sdone_cnt, exp_sdone);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
